// File: rtl/qam_pkg.sv
// Shared constants, Gray level codes and slicer threshold derivation for the
// 16-QAM IF receive path.
package qam_pkg;

    localparam int unsigned IF_W    = 18;
    localparam int unsigned LVL_AMP = 8192;

    typedef enum logic [1:0] {
        LVL_M3 = 2'b00,
        LVL_M1 = 2'b01,
        LVL_P1 = 2'b11,
        LVL_P3 = 2'b10
    } gray_lvl_e;

    // Recovered symbol bits, serialised MSB (i[1]) first
    typedef struct packed {
        logic [1:0] i;
        logic [1:0] q;
    } sym_bits_t;

    // Midpoint between integrals of levels 1 and 3 over a symbol
    function automatic int unsigned thr_calc(input int unsigned sps, input int unsigned amp);
        return 2 * (sps / 2) * amp;
    endfunction

endpackage

// File: rtl/qam_slicer2.sv
// Per-axis 16-QAM Gray slicer: maps a signed integral to its 2-bit level code.
module qam_slicer2
    import qam_pkg::*;
#(
    parameter int unsigned W   = 22,
    parameter int unsigned THR = 65536
) (
    input  logic signed [W-1:0] v,
    output logic [1:0]          code_c
);

    localparam logic signed [W-1:0] POS = W'(THR);
    localparam logic signed [W-1:0] NEG = -POS;

    always_comb begin
        code_c = LVL_P1;
        if (v < NEG) begin
            code_c = LVL_M3;
        end else if (v[W-1]) begin
            code_c = LVL_M1;
        end else if (v >= POS) begin
            code_c = LVL_P3;
        end
    end

endmodule

// File: rtl/qam16_if_demod.sv
// 16-QAM IF demodulator: fs/4 coherent mixer, integrate-and-dump per symbol,
// Gray slicing and MSB-first bit serialiser.
module qam16_if_demod
    import qam_pkg::*;
#(
    parameter int unsigned SPS   = 8,
    parameter int unsigned ACC_W = 22,
    parameter int unsigned THR   = thr_calc(SPS, LVL_AMP)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IF_W-1:0]  IFin,
    input  logic                    align,
    output logic                    Dout,
    output logic                    dout_valid,
    output logic                    sym_done,
    output logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] acc_q
);

    localparam int unsigned CNT_W = $clog2(SPS);
    localparam int unsigned EXT_W = ACC_W - IF_W - 1;

    logic [1:0]              phase, phase_eff;
    logic [CNT_W-1:0]        cnt, cnt_eff;
    logic signed [ACC_W-1:0] accum_i, accum_q;
    logic signed [ACC_W-1:0] base_i, base_q, sum_i, sum_q, xpos, xneg;
    logic signed [IF_W:0]    x19, x19_neg;
    logic                    dump_c;
    sym_bits_t               word_c;
    logic [2:0]              shreg;
    logic [1:0]              bits_left;

    // Mixer and integrator next values; align restarts the symbol at this sample
    always_comb begin
        x19       = {IFin[IF_W-1], IFin};
        x19_neg   = -x19;
        xpos      = {{EXT_W{x19[IF_W]}}, x19};
        xneg      = {{EXT_W{x19_neg[IF_W]}}, x19_neg};
        phase_eff = align ? 2'd0 : phase;
        cnt_eff   = align ? '0 : cnt;
        base_i    = align ? '0 : accum_i;
        base_q    = align ? '0 : accum_q;
        sum_i     = base_i;
        sum_q     = base_q;
        case (phase_eff)
            2'd0:    sum_i = base_i + xpos;
            2'd1:    sum_q = base_q + xneg;
            2'd2:    sum_i = base_i + xneg;
            default: sum_q = base_q + xpos;
        endcase
        dump_c = in_valid && (cnt_eff == CNT_W'(SPS - 1));
    end

    qam_slicer2 #(.W(ACC_W), .THR(THR)) u_slice_i (.v(sum_i), .code_c(word_c.i));
    qam_slicer2 #(.W(ACC_W), .THR(THR)) u_slice_q (.v(sum_q), .code_c(word_c.q));

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase      <= 2'd0;
            cnt        <= '0;
            accum_i    <= '0;
            accum_q    <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            shreg      <= '0;
            bits_left  <= 2'd0;
            Dout       <= 1'b0;
            dout_valid <= 1'b0;
            sym_done   <= 1'b0;
        end else begin
            if (in_valid) begin
                phase   <= phase_eff + 2'd1;
                cnt     <= dump_c ? '0 : cnt_eff + CNT_W'(1);
                accum_i <= dump_c ? '0 : sum_i;
                accum_q <= dump_c ? '0 : sum_q;
            end else if (align) begin
                phase   <= 2'd0;
                cnt     <= '0;
                accum_i <= '0;
                accum_q <= '0;
            end

            if (dump_c) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
            end
            sym_done <= dump_c;

            // First bit leaves on the dump edge; the other three follow from shreg
            if (dump_c) begin
                Dout       <= word_c.i[1];
                shreg      <= {word_c.i[0], word_c.q};
                bits_left  <= 2'd3;
                dout_valid <= 1'b1;
            end else if (bits_left != 2'd0) begin
                Dout       <= shreg[2];
                shreg      <= {shreg[1:0], 1'b0};
                bits_left  <= bits_left - 2'd1;
                dout_valid <= 1'b1;
            end else begin
                Dout       <= 1'b0;
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
